// File: rtl/status_err_mgr_pkg.sv
// Shared register map, response codes and AXI FSM states
// for the status/error manager.
package status_err_mgr_pkg;

  localparam logic [6:0] ADDR_MASK   = 7'h7F;
  localparam logic [6:0] IDX_QSFP    = 7'd0;
  localparam logic [6:0] IDX_LATCHED = 7'd1;
  localparam logic [6:0] IDX_MASK    = 7'd2;
  localparam logic [6:0] IDX_CNT_CLR = 7'd3;
  localparam logic [6:0] IDX_LIVE    = 7'd4;
  localparam logic [6:0] IDX_CNT     = 7'd8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_st_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_st_t;

  // Holes and words past the last counter decode to DECERR;
  // writes to read-only words are refused with SLVERR.
  function automatic logic [1:0] acc_resp(
    input logic [6:0]  idx,
    input logic        wr,
    input int unsigned num_err
  );
    logic [1:0] r;
    r = RESP_OKAY;
    if ((idx > IDX_LIVE && idx < IDX_CNT) ||
        32'(idx) >= 32'd8 + num_err)
      r = RESP_DECERR;
    else if (wr && (idx == IDX_QSFP ||
                    idx == IDX_LIVE ||
                    idx >= IDX_CNT))
      r = RESP_SLVERR;
    return r;
  endfunction

endpackage

// File: rtl/status_err_mgr_err_cell.sv
// One error channel: sticky latch with W1C and a
// saturating event counter.
module err_cell #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             pulse,
  input  logic             clr_latch,
  input  logic             clr_cnt,
  output logic             latched,
  output logic [CNT_W-1:0] cnt
);

  logic             latched_d, latched_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // A new pulse always beats a clear in the same cycle.
  always_comb begin
    latched_d = pulse | (latched_q & ~clr_latch);
    cnt_d     = cnt_q;
    if (clr_cnt)
      cnt_d = CNT_W'(pulse);
    else if (pulse && cnt_q != '1)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      latched_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      latched_q <= latched_d;
      cnt_q     <= cnt_d;
    end
  end

  assign latched = latched_q;
  assign cnt     = cnt_q;

endmodule

// File: rtl/status_err_mgr.sv
// Status/error manager: QSFP status, latched error strobes,
// counters, LEDs and irq behind an AXI4-Lite slave.
module status_err_mgr #(
  parameter int FREQ_HZ  = 250000000,
  parameter int NUM_QSFP = 2,
  parameter int NUM_ERR  = 8,
  parameter int BLINK_HZ = 2,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NUM_QSFP-1:0] qsfp_status,
  input  logic [NUM_ERR-1:0]  err_pulse,
  output logic [3:0]          led_orang_l,
  output logic [3:0]          led_green_l,
  output logic                irq,
  input  logic [31:0]         S_AXI_AWADDR,
  input  logic [2:0]          S_AXI_AWPROT,
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  input  logic [31:0]         S_AXI_WDATA,
  input  logic [3:0]          S_AXI_WSTRB,
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  output logic [1:0]          S_AXI_BRESP,
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  input  logic [31:0]         S_AXI_ARADDR,
  input  logic [2:0]          S_AXI_ARPROT,
  input  logic                S_AXI_ARVALID,
  output logic                S_AXI_ARREADY,
  output logic [31:0]         S_AXI_RDATA,
  output logic [1:0]          S_AXI_RRESP,
  output logic                S_AXI_RVALID,
  input  logic                S_AXI_RREADY
);

  import status_err_mgr_pkg::*;

  localparam int HP  = FREQ_HZ / (2 * BLINK_HZ);
  localparam int HPC = (HP < 1) ? 1 : HP;
  localparam int BW  = (HPC > 1) ? $clog2(HPC) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(HPC - 1);

  wr_st_t      wst_q;
  rd_st_t      rst_q;
  logic        awready_q, wready_q, bvalid_q;
  logic        arready_q, rvalid_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q;

  logic [NUM_ERR-1:0] latched, clr_lat, clr_cnt;
  logic [CNT_W-1:0]   cnt [NUM_ERR];
  logic [NUM_ERR-1:0] mask_d, mask_q, live_d, live_q;
  logic               irq_d, irq_q, blink_d, blink_q;
  logic [BW-1:0]      bcnt_d, bcnt_q;
  logic               err_any, ashi_write, wr_ok;
  logic [6:0]         wr_idx, rd_idx;
  logic [1:0]         wr_resp, rd_resp;
  logic [31:0]        rd_data;
  logic               unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB,
                       S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WDATA};

  assign wr_idx     = S_AXI_AWADDR[8:2] & ADDR_MASK;
  assign rd_idx     = S_AXI_ARADDR[8:2] & ADDR_MASK;
  assign wr_resp    = acc_resp(wr_idx, 1'b1, NUM_ERR);
  assign rd_resp    = acc_resp(rd_idx, 1'b0, NUM_ERR);
  assign ashi_write = (wst_q == W_DATA);
  assign wr_ok      = ashi_write && (wr_resp == RESP_OKAY);
  assign err_any    = |(latched & mask_q);

  always_comb begin
    clr_lat = '0;
    clr_cnt = '0;
    mask_d  = mask_q;
    if (wr_ok && wr_idx == IDX_LATCHED)
      clr_lat = S_AXI_WDATA[NUM_ERR-1:0];
    if (wr_ok && wr_idx == IDX_CNT_CLR)
      clr_cnt = S_AXI_WDATA[NUM_ERR-1:0];
    if (wr_ok && wr_idx == IDX_MASK)
      mask_d = S_AXI_WDATA[NUM_ERR-1:0];
    live_d  = err_pulse;
    irq_d   = err_any;
    bcnt_d  = (bcnt_q == B_LAST) ? '0 : bcnt_q + BW'(1);
    blink_d = (bcnt_q == B_LAST) ? ~blink_q : blink_q;
  end

  for (genvar k = 0; k < NUM_ERR; k++) begin : g_cell
    err_cell #(.CNT_W(CNT_W)) u_cell (
      .clk       (clk),
      .resetn    (resetn),
      .pulse     (err_pulse[k]),
      .clr_latch (clr_lat[k]),
      .clr_cnt   (clr_cnt[k]),
      .latched   (latched[k]),
      .cnt       (cnt[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mask_q  <= '1;
      live_q  <= '0;
      irq_q   <= 1'b0;
      bcnt_q  <= '0;
      blink_q <= 1'b0;
    end else begin
      mask_q  <= mask_d;
      live_q  <= live_d;
      irq_q   <= irq_d;
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      rd_resp != RESP_OKAY:   rd_data = '0;
      rd_idx == IDX_QSFP:     rd_data = 32'(qsfp_status);
      rd_idx == IDX_LATCHED:  rd_data = 32'(latched);
      rd_idx == IDX_MASK:     rd_data = 32'(mask_q);
      rd_idx == IDX_LIVE:     rd_data = 32'(live_q);
      default: begin
        for (int k = 0; k < NUM_ERR; k++)
          if (rd_idx == 7'(IDX_CNT + k))
            rd_data = 32'(cnt[k]);
      end
    endcase
  end

  // Address and data are taken together; side effects land
  // on the edge that closes the W_DATA cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wst_q     <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      unique case (wst_q)
        W_IDLE:
          if (S_AXI_AWVALID && S_AXI_WVALID) begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wst_q     <= W_DATA;
          end
        W_DATA: begin
          awready_q <= 1'b0;
          wready_q  <= 1'b0;
          bvalid_q  <= 1'b1;
          bresp_q   <= wr_resp;
          wst_q     <= W_RESP;
        end
        W_RESP:
          if (S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
            wst_q    <= W_IDLE;
          end
        default: wst_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rst_q     <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      unique case (rst_q)
        R_IDLE:
          if (S_AXI_ARVALID) begin
            arready_q <= 1'b1;
            rst_q     <= R_ADDR;
          end
        R_ADDR: begin
          arready_q <= 1'b0;
          rvalid_q  <= 1'b1;
          rdata_q   <= rd_data;
          rresp_q   <= rd_resp;
          rst_q     <= R_DATA;
        end
        R_DATA:
          if (S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
            rst_q    <= R_IDLE;
          end
        default: rst_q <= R_IDLE;
      endcase
    end
  end

  always_comb begin
    led_green_l = 4'hF;
    led_orang_l = 4'hF;
    for (int i = 0; i < NUM_QSFP; i++) begin
      led_green_l[i] = ~qsfp_status[i];
      led_orang_l[i] = qsfp_status[i];
    end
    led_green_l[3] = err_any;
    led_orang_l[3] = ~(err_any & blink_q);
  end

  assign irq           = irq_q;
  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

endmodule
